// File: rtl/mult_sched_if.sv
// Handshake and operand bundle between the two requesters and the shift-add multiplier scheduler.
interface mult_sched_if;
    logic       activate;
    logic       req0;
    logic       req1;
    logic [7:0] a0;
    logic [7:0] a1;
    logic [7:0] b0;
    logic [7:0] b1;
    logic       grant0;
    logic       grant1;
    logic       busy;
    logic       done;
    logic       done_id;
    logic [7:0] mult8;
    logic [7:0] mult16;

    modport master (
        output activate, req0, req1, a0, a1, b0, b1,
        input  grant0, grant1, busy, done, done_id, mult8, mult16
    );

    modport slave (
        input  activate, req0, req1, a0, a1, b0, b1,
        output grant0, grant1, busy, done, done_id, mult8, mult16
    );
endinterface

// File: rtl/mult_sched.sv
// Two-requester scheduler for a sequential 8x8 shift-add multiplier (8 iterations, LSB first).
// state | meaning
// IDLE  | waiting for an arbitration win; RUN: one iteration per enabled cycle; DONE: result valid pulse
module mult_sched #(
    parameter bit FIX_PRIO = 1'b0
) (
    input logic        clk,
    input logic        reset,
    mult_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [15:0] acc_q, acc_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        last_q, last_d;
    logic        owner_q, owner_d;
    logic        grant0_q, grant0_d;
    logic        grant1_q, grant1_d;
    logic [15:0] res_q, res_d;
    logic        done_id_q, done_id_d;

    logic        win0;
    logic        win1;
    logic [15:0] addend;
    logic [15:0] acc_sum;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        owner_d   = owner_q;
        grant0_d  = 1'b0;
        grant1_d  = 1'b0;
        res_d     = res_q;
        done_id_d = done_id_q;
        // last_q=1 means requester 1 was served last, so requester 0 wins a tie
        win0      = bus.req0 && (FIX_PRIO || !bus.req1 || last_q);
        win1      = bus.req1 && !win0;
        addend    = a_q[0] ? ({8'h00, b_q} << cnt_q) : 16'h0000;
        acc_sum   = acc_q + addend;

        case (state_q)
            IDLE: begin
                if (bus.activate && (win0 || win1)) begin
                    a_d      = win0 ? bus.a0 : bus.a1;
                    b_d      = win0 ? bus.b0 : bus.b1;
                    acc_d    = 16'h0000;
                    cnt_d    = 3'd0;
                    grant0_d = win0;
                    grant1_d = win1;
                    owner_d  = win1;
                    last_d   = win1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (bus.activate) begin
                    acc_d = acc_sum;
                    a_d   = a_q >> 1;
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        res_d     = acc_sum;
                        done_id_d = owner_q;
                        state_d   = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            a_q       <= 8'h00;
            b_q       <= 8'h00;
            acc_q     <= 16'h0000;
            cnt_q     <= 3'd0;
            last_q    <= 1'b1;
            owner_q   <= 1'b0;
            grant0_q  <= 1'b0;
            grant1_q  <= 1'b0;
            res_q     <= 16'h0000;
            done_id_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            grant0_q  <= grant0_d;
            grant1_q  <= grant1_d;
            res_q     <= res_d;
            done_id_q <= done_id_d;
        end
    end

    assign bus.grant0  = grant0_q;
    assign bus.grant1  = grant1_q;
    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = (state_q == DONE);
    assign bus.done_id = done_id_q;
    assign bus.mult8   = res_q[7:0];
    assign bus.mult16  = res_q[15:8];
endmodule

// File: tb/tb_mult_sched.sv
// Self-checking bench for mult_sched: directed scenarios plus randomized operations against a
// behavioural model (plain product, cycle-count latency, tb-side last-served arbitration).
module tb_mult_sched;
    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    bit   last_srv;

    mult_sched_if bus ();
    mult_sched_if bus_f ();

    mult_sched #(.FIX_PRIO(1'b0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    mult_sched #(.FIX_PRIO(1'b1)) dut_f (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_win(input bit r0, input bit r1);
        if (r0 && r1) return last_srv ? 0 : 1;
        if (r0) return 0;
        return 1;
    endfunction

    // one full operation starting from an IDLE cycle; stall drops activate for st_len cycles from cycle st_at
    task automatic do_op(input bit r0, input bit r1, input logic [7:0] x0, input logic [7:0] y0,
                         input logic [7:0] x1, input logic [7:0] y1, input int st_at, input int st_len,
                         input string tag);
        int          w;
        int          cyc;
        bit          seen;
        logic [15:0] prod;
        bus.req0 = r0;
        bus.req1 = r1;
        bus.a0 = x0;
        bus.b0 = y0;
        bus.a1 = x1;
        bus.b1 = y1;
        bus.activate = 1'b1;
        w = model_win(r0, r1);
        prod = (w == 0) ? 16'(x0) * 16'(y0) : 16'(x1) * 16'(y1);
        last_srv = (w == 1);
        tick();
        chk({tag, "_grant0"}, bus.grant0, (w == 0));
        chk({tag, "_grant1"}, bus.grant1, (w == 1));
        chk({tag, "_busy"}, bus.busy, 1);
        chk({tag, "_nodone"}, bus.done, 0);
        if (w == 0) bus.req0 = 1'b0;
        else bus.req1 = 1'b0;
        bus.a0 = 8'($urandom);
        bus.b0 = 8'($urandom);
        bus.a1 = 8'($urandom);
        bus.b1 = 8'($urandom);
        seen = 1'b0;
        for (cyc = 1; cyc <= 30; cyc++) begin
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (cyc > 1) begin
                chk({tag, "_run_grant"}, {bus.grant0, bus.grant1}, 0);
                chk({tag, "_run_busy"}, bus.busy, 1);
            end
            if (cyc == st_at) bus.activate = 1'b0;
            if (cyc == st_at + st_len) bus.activate = 1'b1;
            tick();
        end
        chk({tag, "_done_seen"}, seen, 1);
        chk({tag, "_done_cycle"}, cyc, 9 + st_len);
        chk({tag, "_result"}, {bus.mult16, bus.mult8}, prod);
        chk({tag, "_done_id"}, bus.done_id, w);
        chk({tag, "_done_grant"}, {bus.grant0, bus.grant1}, 0);
        tick();
        chk({tag, "_post_done"}, bus.done, 0);
        chk({tag, "_post_busy"}, bus.busy, 0);
        chk({tag, "_hold_result"}, {bus.mult16, bus.mult8}, prod);
        chk({tag, "_hold_id"}, bus.done_id, w);
    endtask

    initial begin
        int g0;
        int g1;
        int bad_id;
        n_tests = 0;
        n_fail = 0;
        last_srv = 1'b1;
        reset = 1'b1;
        bus.activate = 1'b0;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.a0 = 8'h00;
        bus.b0 = 8'h00;
        bus.a1 = 8'h00;
        bus.b1 = 8'h00;
        bus_f.activate = 1'b0;
        bus_f.req0 = 1'b0;
        bus_f.req1 = 1'b0;
        bus_f.a0 = 8'h00;
        bus_f.b0 = 8'h00;
        bus_f.a1 = 8'h00;
        bus_f.b1 = 8'h00;
        tick();
        tick();
        chk("rst_grant", {bus.grant0, bus.grant1}, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_done_id", bus.done_id, 0);
        chk("rst_mult", {bus.mult16, bus.mult8}, 0);
        reset = 1'b0;

        do_op(1, 0, 8'd13, 8'd11, 8'd0, 8'd0, 0, 0, "basic");
        do_op(0, 1, 8'd0, 8'd0, 8'hFF, 8'hFF, 0, 0, "max");
        do_op(1, 0, 8'd2, 8'd100, 8'd0, 8'd0, 3, 3, "stall");
        do_op(1, 0, 8'd0, 8'd200, 8'd0, 8'd0, 0, 0, "zero");

        // contention straight out of reset: req0 first, then req1 granted at cycle 11
        reset = 1'b1;
        tick();
        reset = 1'b0;
        last_srv = 1'b1;
        do_op(1, 1, 8'd3, 8'd5, 8'd7, 8'd9, 0, 0, "cont_a");
        do_op(0, 1, 8'd3, 8'd5, 8'd7, 8'd9, 0, 0, "cont_b");

        // a request dropped while activate is low must not be remembered
        bus.activate = 1'b0;
        bus.req0 = 1'b1;
        tick();
        chk("drop_nogrant", {bus.grant0, bus.grant1}, 0);
        bus.req0 = 1'b0;
        bus.activate = 1'b1;
        tick();
        tick();
        chk("drop_idle_grant", {bus.grant0, bus.grant1}, 0);
        chk("drop_idle_busy", bus.busy, 0);

        // reset in cycle 5 of an operation
        bus.req0 = 1'b1;
        bus.a0 = 8'd9;
        bus.b0 = 8'd9;
        tick();
        bus.req0 = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        chk("mrst_done", bus.done, 0);
        chk("mrst_busy", bus.busy, 0);
        chk("mrst_mult", {bus.mult16, bus.mult8}, 0);
        chk("mrst_done_id", bus.done_id, 0);
        chk("mrst_grant", {bus.grant0, bus.grant1}, 0);
        reset = 1'b0;
        last_srv = 1'b1;
        tick();
        chk("mrst_idle_done", bus.done, 0);
        do_op(1, 1, 8'd21, 8'd6, 8'd4, 8'd4, 0, 0, "after_rst");

        for (int i = 0; i < 16; i++) begin
            int r;
            int sl;
            bus.activate = 1'b0;
            bus.req0 = 1'($urandom);
            bus.req1 = 1'($urandom);
            tick();
            chk("rnd_gap_grant", {bus.grant0, bus.grant1}, 0);
            chk("rnd_gap_busy", bus.busy, 0);
            r = $urandom_range(1, 3);
            sl = $urandom_range(0, 3);
            do_op(r[0], r[1], 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                  $urandom_range(2, 5), sl, "rnd");
        end

        // fixed priority: req0 held forever, req1 never served
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus_f.activate = 1'b1;
        bus_f.req0 = 1'b1;
        bus_f.req1 = 1'b1;
        bus_f.a0 = 8'd6;
        bus_f.b0 = 8'd7;
        bus_f.a1 = 8'd1;
        bus_f.b1 = 8'd1;
        g0 = 0;
        g1 = 0;
        bad_id = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (bus_f.grant0 === 1'b1) g0++;
            if (bus_f.grant1 === 1'b1) g1++;
            if (bus_f.done === 1'b1 && (bus_f.done_id !== 1'b0 || {bus_f.mult16, bus_f.mult8} !== 16'd42))
                bad_id++;
        end
        chk("fix_grant1", g1, 0);
        chk("fix_grant0", g0, 4);
        chk("fix_result", bad_id, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mult_sched.md
MULT_SCHED -- requirements
Module: mult_sched

Interface
REQ-001 SHALL have parameter FIX_PRIO, default 0, meaning 0 = round-robin arbitration and 1 = fixed priority with req0 always winning.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port activate, input, 1, global enable; low stalls the block.
REQ-005 SHALL have ports req0 and req1, input, 1 each, requester operation requests, level, held until granted.
REQ-006 SHALL have ports a0 and a1, input, 8 each, multiplier operand of requester 0 and requester 1.
REQ-007 SHALL have ports b0 and b1, input, 8 each, multiplicand operand of requester 0 and requester 1.
REQ-008 SHALL have ports grant0 and grant1, output, 1 each, one-cycle pulse acknowledging operand capture.
REQ-009 SHALL have port busy, output, 1, high in every non-IDLE state.
REQ-010 SHALL have port done, output, 1, one-cycle pulse when the result is valid.
REQ-011 SHALL have port done_id, output, 1, index of the requester owning the current result.
REQ-012 SHALL have port mult8, output, 8, low byte of the product.
REQ-013 SHALL have port mult16, output, 8, high byte of the product.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
- IDLE->RUN on arbitration win.
- RUN->DONE after 8 iterations.
- DONE->IDLE unconditionally on the next edge.
REQ-015 SHALL arbitrate only in IDLE with activate=1; no request is sampled in RUN or DONE.
REQ-016 SHALL, on the arbitration edge, do all of the following:
- capture the winner's a and b into internal registers;
- clear the 16-bit accumulator and the 3-bit iteration counter;
- set grantN=1 for exactly the following cycle.
REQ-017 SHALL, in round-robin mode, give a lone requester the grant.
REQ-018 SHALL, in round-robin mode, on simultaneous req0 and req1, grant the requester not served last; the last-served pointer resets to 1, so req0 wins first after reset.
REQ-019 SHALL perform one iteration per RUN cycle with activate=1, LSB first.
- If a_reg[0]=1, the accumulator SHALL add b_reg shifted left by the iteration index (16-bit, no overflow possible).
- a_reg SHALL then shift right by 1.
REQ-020 SHALL freeze state, counter, accumulator and operand registers in any cycle where activate=0; a stall adds exactly one cycle of latency per stalled cycle.
REQ-021 SHALL, on the edge completing iteration 7, load {mult16,mult8} from the final accumulator, load done_id, and enter DONE.
REQ-022 SHALL assert done=1 for exactly the DONE cycle, regardless of activate.
REQ-023 SHALL hold mult8, mult16 and done_id stable from the DONE cycle until the next DONE.
REQ-024 SHALL have the following latency, with the arbitration edge at cycle 0 and no stall:
- grant high in cycle 1;
- RUN iterations on edges 1..8;
- done high in cycle 9;
- earliest next grant in cycle 11.
REQ-025 SHALL always take 8 iterations, including for operands equal to 0; there is no early termination.
REQ-026 SHALL never assert grant0 and grant1 in the same cycle, and SHALL never assert done and grantN in the same cycle.
REQ-027 SHALL ignore a request deasserted before it is granted, and SHALL NOT queue it.

Reset
REQ-028 SHALL, on reset=1 at a rising edge, force state=IDLE, last-served pointer=1, accumulator=0, counter=0 and operand registers=0.
REQ-029 SHALL drive grant0=0, grant1=0, busy=0, done=0, done_id=0, mult8=0x00 and mult16=0x00 in the cycle after reset.
REQ-030 SHALL give reset priority over activate and over all FSM transitions.
REQ-031 SHALL, on reset during RUN or DONE, abort the operation with no done pulse, zero the outputs, and start no arbitration in that cycle.

Verification
REQ-032 SHALL pass a basic-multiply check:
- stimulus: after reset, req0=1, a0=13, b0=11;
- response: grant0 in cycle 1, done in cycle 9, {mult16,mult8}=0x008F, done_id=0.
REQ-033 SHALL pass a maximum-operand check:
- stimulus: req1=1, a1=0xFF, b1=0xFF;
- response: grant1, then done with mult16=0xFE, mult8=0x01, done_id=1.
REQ-034 SHALL pass a contention check:
- stimulus: req0 and req1 held high from reset release, a0=3, b0=5, a1=7, b1=9, FIX_PRIO=0;
- response: result 0x000F with done_id=0 at cycle 9, then grant1 at cycle 11, then result 0x003F with done_id=1.
- With FIX_PRIO=1 and req0 held, req1 SHALL never be granted.
REQ-035 SHALL pass a stall check:
- stimulus: a0=2, b0=100, activate=0 for 3 cycles mid-RUN;
- response: done in cycle 12, result 0x00C8, no grant during the stall.
REQ-036 SHALL pass a mid-operation reset check:
- stimulus: reset=1 in cycle 5 of an operation;
- response: no done, mult8=mult16=0, busy=0 next cycle, and a fresh request is then granted normally.
REQ-037 SHALL pass a zero-operand check:
- stimulus: a0=0, b0=200;
- response: done still in cycle 9, result 0x0000.
